// File: rtl/modulo_issue_arbiter_if.sv
// Requester-side bundle for the modulo issue arbiter:
// request handshake plus the shared response bus.
interface modulo_issue_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_dz;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data, rsp_dz
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data, rsp_dz
  );
endinterface

// File: rtl/modulo_issue_arbiter.sv
// Round-robin issue arbiter in front of a fixed-latency
// modulo unit, with a tag pipe routing results home.
module modulo_issue_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = 32,
  parameter int LATENCY      = 49,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  modulo_issue_arbiter_if.slave rq,
  output logic [WIDTH-1:0]     mod_a,
  output logic [WIDTH-1:0]     mod_b,
  input  logic [WIDTH-1:0]     mod_out,
  output logic                 idle
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_INFLIGHT + 1);

  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
    logic           dz;
  } tag_t;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt;
  logic               take;
  logic [IDW-1:0]     gnt_id;
  logic [WIDTH-1:0]   win_b;
  logic [NUM_REQ-1:0] rsp_hot;
  tag_t               last;

  logic [IDW-1:0]   start_q, start_d;
  logic [WIDTH-1:0] mod_a_q, mod_a_d;
  logic [WIDTH-1:0] mod_b_q, mod_b_d;
  tag_t             tag_q [LATENCY+1];
  tag_t             tag_d [LATENCY+1];
  logic [CW-1:0]    cnt_q [NUM_REQ];
  logic [CW-1:0]    cnt_d [NUM_REQ];

  // A requester competes only while it has credit left.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = rq.req_valid[i] &&
                (cnt_q[i] < CW'(MAX_INFLIGHT));
    end
  end

  // Round-robin search from the slot after the last winner.
  always_comb begin
    int idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    gnt_id = '0;
    gnt    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(start_q) + k) % NUM_REQ;
      if (!found && elig[IDW'(idx)]) begin
        found  = 1'b1;
        gnt_id = IDW'(idx);
      end
    end
    take = found && rst_n;
    if (take) gnt[gnt_id] = 1'b1;
  end

  assign rq.req_ready = gnt;

  // Operand capture, pointer advance and tag pipe shift.
  always_comb begin
    start_d  = start_q;
    mod_a_d  = mod_a_q;
    mod_b_d  = mod_b_q;
    win_b    = rq.req_b[gnt_id*WIDTH +: WIDTH];
    tag_d[0] = '0;
    if (take) begin
      start_d = (gnt_id == IDW'(NUM_REQ - 1)) ?
                '0 : gnt_id + 1'b1;
      mod_a_d = rq.req_a[gnt_id*WIDTH +: WIDTH];
      mod_b_d = win_b;
      tag_d[0].v  = 1'b1;
      tag_d[0].id = gnt_id;
      tag_d[0].dz = (win_b == '0);
    end
    for (int k = 1; k <= LATENCY; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  // Last tag lines up with mod_out; b=0 results are masked.
  always_comb begin
    last     = tag_q[LATENCY];
    rsp_hot  = '0;
    if (last.v && rst_n) rsp_hot[last.id] = 1'b1;
    rq.rsp_valid = rsp_hot;
    rq.rsp_dz    = last.v && rst_n && last.dz;
    rq.rsp_data  = (last.v && rst_n && !last.dz) ?
                   mod_out : '0;
  end

  // Per-requester credit tracking and idle detect.
  always_comb begin
    idle = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt[i] && !rsp_hot[i]) cnt_d[i] = cnt_q[i] + 1'b1;
      if (!gnt[i] && rsp_hot[i]) cnt_d[i] = cnt_q[i] - 1'b1;
      if (cnt_q[i] != '0) idle = 1'b0;
    end
  end

  // State registers; reset drops every tag still in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q <= '0;
      mod_a_q <= '0;
      mod_b_q <= '0;
      for (int k = 0; k <= LATENCY; k++) tag_q[k] <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      start_q <= start_d;
      mod_a_q <= mod_a_d;
      mod_b_q <= mod_b_d;
      for (int k = 0; k <= LATENCY; k++) tag_q[k] <= tag_d[k];
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
        assert (!(rsp_hot[i] && cnt_q[i] == '0));
        assert (!(gnt[i] && !rsp_hot[i] &&
                  cnt_q[i] == CW'(MAX_INFLIGHT)));
      end
    end
  end

  assign mod_a = mod_a_q;
  assign mod_b = mod_b_q;
endmodule

// File: tb/tb_modulo_issue_arbiter.sv
// Scoreboard bench for modulo_issue_arbiter with a
// behavioural modulo unit and queue-based reference model.
module tb_modulo_issue_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 49;
  localparam int M = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] mod_a, mod_b, mod_out;
  logic idle;

  always #5 clk = ~clk;

  modulo_issue_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  modulo_issue_arbiter #(
    .NUM_REQ(N), .WIDTH(W), .LATENCY(L), .MAX_INFLIGHT(M)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rq(bus),
    .mod_a(mod_a), .mod_b(mod_b),
    .mod_out(mod_out), .idle(idle)
  );

  // Modulo unit: L-deep pipe, garbage for b=0.
  logic [W-1:0] pipe [L];
  always @(posedge clk) begin
    for (int k = L-1; k > 0; k--) pipe[k] <= pipe[k-1];
    pipe[0] <= (mod_b == 0) ? 32'hDEADBEEF : mod_a % mod_b;
  end
  assign mod_out = pipe[L-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] d;
    logic         dz;
    int           e;
  } exp_t;

  exp_t q [N][$];
  int n_chk = 0;
  int n_fail = 0;
  int last_g = N-1;
  int rsp_seen = 0;
  int gcount [N];

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int total();
    int s = 0;
    for (int i = 0; i < N; i++) s += q[i].size();
    return s;
  endfunction

  // One cycle of stimulus plus the reference arbitration model.
  task automatic step(input logic rst, input logic [N-1:0] v,
                      input logic [N*W-1:0] av,
                      input logic [N*W-1:0] bv);
    logic [N-1:0] exp_rdy;
    int g;
    exp_t e;
    @(negedge clk);
    rst_n = rst;
    bus.req_valid = v;
    bus.req_a = av;
    bus.req_b = bv;
    #2;
    exp_rdy = '0;
    g = -1;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (last_g + 1 + k) % N;
        if (g < 0 && v[idx] && q[idx].size() < M) g = idx;
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk(idle == (total() == 0), "idle", 64'(idle),
          64'(total() == 0));
    end
    chk(bus.req_ready == exp_rdy, "req_ready",
        64'(bus.req_ready), 64'(exp_rdy));
    if (!rst) begin
      for (int i = 0; i < N; i++) q[i].delete();
      last_g = N-1;
    end else if (g >= 0) begin
      e.dz = (bv[g*W +: W] == 0);
      e.d  = e.dz ? '0 : av[g*W +: W] % bv[g*W +: W];
      e.e  = cyc + 1;
      q[g].push_back(e);
      gcount[g]++;
      last_g = g;
    end
  endtask

  task automatic idle_steps(input int n);
    repeat (n) step(1'b1, '0, '0, '0);
  endtask

  // Monitor: pop and compare every response the DUT presents.
  initial begin
    exp_t e;
    int id;
    forever begin
      @(negedge clk);
      #4;
      if (bus.rsp_valid != 0) begin
        rsp_seen++;
        id = 0;
        for (int i = 0; i < N; i++) if (bus.rsp_valid[i]) id = i;
        chk($onehot(bus.rsp_valid), "rsp_onehot",
            64'(bus.rsp_valid), 64'(1 << id));
        if (q[id].size() == 0) begin
          chk(1'b0, "rsp_unexpected", 64'(bus.rsp_valid), 0);
        end else begin
          e = q[id].pop_front();
          chk(bus.rsp_data == e.d, "rsp_data",
              64'(bus.rsp_data), 64'(e.d));
          chk(bus.rsp_dz == e.dz, "rsp_dz",
              64'(bus.rsp_dz), 64'(e.dz));
          chk(cyc == e.e + L, "rsp_latency",
              64'(cyc - e.e), 64'(L));
        end
      end else begin
        chk(bus.rsp_data == 0 && bus.rsp_dz == 0, "rsp_idle",
            {31'd0, bus.rsp_dz, bus.rsp_data}, 0);
      end
    end
  end

  initial begin
    logic [N*W-1:0] av, bv;
    int g0, guard;
    for (int i = 0; i < N; i++) gcount[i] = 0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;

    // Reset with everyone requesting: nothing may be granted.
    step(1'b0, '1, '0, '0);
    step(1'b0, '1, '0, '0);
    @(posedge clk);
    #1;
    chk(mod_a == 0 && mod_b == 0, "reset_mod",
        {mod_a, mod_b}, 0);
    chk(idle == 1'b1, "reset_idle", 64'(idle), 1);
    chk(bus.rsp_valid == 0, "reset_rsp",
        64'(bus.rsp_valid), 0);

    // Single request from requester 2.
    av = '0;
    bv = '0;
    av[2*W +: W] = 100;
    bv[2*W +: W] = 7;
    step(1'b1, 4'b0100, av, bv);
    idle_steps(L + 5);

    // All four requesters, round-robin order.
    for (int i = 0; i < N; i++) begin
      av[i*W +: W] = 1000 + i;
      bv[i*W +: W] = 13;
    end
    repeat (12) step(1'b1, '1, av, bv);
    idle_steps(L + 5);

    // Divide by zero on requester 1.
    av = '0;
    bv = '0;
    av[1*W +: W] = 55;
    step(1'b1, 4'b0010, av, bv);
    idle_steps(L + 5);

    // Credit limit on requester 0.
    g0 = gcount[0];
    repeat (20) begin
      av[0 +: W] = $urandom;
      bv[0 +: W] = $urandom_range(1, 5000);
      step(1'b1, 4'b0001, av, bv);
    end
    chk(gcount[0] - g0 == M, "limit_grants",
        64'(gcount[0] - g0), 64'(M));
    repeat (60) begin
      av[0 +: W] = $urandom;
      bv[0 +: W] = $urandom_range(1, 5000);
      step(1'b1, 4'b0001, av, bv);
    end
    idle_steps(L + 20);

    // Reset while ten requests are inside the unit.
    for (int i = 0; i < N; i++) begin
      av[i*W +: W] = $urandom;
      bv[i*W +: W] = $urandom_range(1, 99);
    end
    repeat (10) step(1'b1, '1, av, bv);
    idle_steps(4);
    step(1'b0, '0, '0, '0);
    rsp_seen = 0;
    idle_steps(L + 1);
    chk(rsp_seen == 0, "reset_flush", 64'(rsp_seen), 0);
    chk(idle == 1'b1, "reset_idle2", 64'(idle), 1);
    av = '0;
    bv = '0;
    av[3*W +: W] = 77;
    bv[3*W +: W] = 10;
    step(1'b1, 4'b1000, av, bv);
    idle_steps(L + 5);

    // Random mixed load.
    repeat (2000) begin
      for (int i = 0; i < N; i++) begin
        av[i*W +: W] = $urandom;
        bv[i*W +: W] = ($urandom_range(0, 9) == 0) ?
                       '0 : W'($urandom_range(1, 100000));
      end
      step(1'b1, N'($urandom_range(0, 15)), av, bv);
    end

    // Drain with a bounded wait.
    guard = 0;
    while (total() != 0 && guard < 200) begin
      idle_steps(1);
      guard++;
    end
    chk(total() == 0, "drain", 64'(total()), 0);
    idle_steps(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
